crypt_reg_if: RTL and testbench

CRYPT_REG_IF -- requirements
Module: crypt_reg_if

---
 rtl/crypt_reg_if_pkg.sv | 42 ++++
 rtl/crypt_reg_if_encrypter.sv | 34 +++
 rtl/crypt_reg_if.sv | 154 +++++++++++++++
 tb/tb_crypt_reg_if.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_reg_if_pkg.sv
// Shared definitions for crypt_reg_if: FSM encoding, CMD/STATUS bit positions and address map helpers.
// Definitions only; no latency and no backpressure.
package crypt_reg_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam int CMD_START  = 0;
  localparam int CMD_IRQ_EN = 1;
  localparam int CMD_CLR    = 2;

  localparam int STAT_BUSY        = 0;
  localparam int STAT_DONE        = 1;
  localparam int STAT_ERR_BUSY    = 2;
  localparam int STAT_ERR_TIMEOUT = 3;

  localparam int OFF_CMD    = 0;
  localparam int OFF_STATUS = 1;
  localparam int DIN_BASE   = 2;

  function automatic int kin_base(input int n);
    return DIN_BASE + n;
  endfunction

  function automatic int dout_base(input int n);
    return DIN_BASE + 2 * n;
  endfunction

  function automatic int kout_base(input int n);
    return DIN_BASE + 3 * n;
  endfunction

  // One past the last mapped address.
  function automatic int map_end(input int n);
    return DIN_BASE + 4 * n;
  endfunction

endpackage

// File: rtl/crypt_reg_if_encrypter.sv
// Iterative toy cipher core: loads data/key while set is high, then runs ROUNDS rounds and raises status.
// Latency ROUNDS cycles after set falls; status holds until set is raised again, no backpressure.
module Encrypter #(
  parameter int W      = 64,
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         set,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] key_in,
  output logic         status,
  output logic [W-1:0] data_out,
  output logic [W-1:0] key_out
);
  localparam int CW = $clog2(ROUNDS + 1);

  logic [CW-1:0] round;

  always_ff @(posedge clk) begin
    if (set) begin
      data_out <= data_in;
      key_out  <= key_in;
      round    <= '0;
      status   <= 1'b0;
    end else if (!status) begin
      // Data mixes with the pre-rotation key; the key schedule is a rotate-left by 3.
      data_out <= {data_out[W-2:0], data_out[W-1]} ^ key_out;
      key_out  <= {key_out[W-4:0], key_out[W-1:W-3]};
      round    <= round + 1'b1;
      status   <= (round == CW'(ROUNDS - 1));
    end
  end

endmodule

// File: rtl/crypt_reg_if.sv
// Byte-wide register front end for the Encrypter core: command/status, block buffers, load/run/capture sequencing.
// Reads return one cycle after re; no backpressure, writes take effect on the edge they are presented.
module crypt_reg_if
  import crypt_reg_if_pkg::*;
#(
  parameter int BLOCK_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 6,
  parameter int CORE_ROUNDS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  output logic [7:0]        byte_read,
  output logic              irq
);
  localparam int N  = BLOCK_BYTES;
  localparam int W  = 8 * N;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          core_set, core_status, busy;
  logic          irq_en, done, err_busy, err_timeout;
  logic [TW-1:0] run_cnt;
  logic [W-1:0]  din, kin, dout, kout;
  logic [W-1:0]  core_din, core_kin, core_dout, core_kout;
  int            a;
  logic          wr_cmd, start_req, clr_req, wr_blk;
  logic [7:0]    rd_val;

  // Byte offset 0 is the most significant byte of the block.
  function automatic logic [7:0] blk_byte(input logic [W-1:0] blk, input int idx);
    return blk[8*(N-1-idx) +: 8];
  endfunction

  assign busy = (state != S_IDLE);

  always_comb begin
    a         = int'(addr);
    wr_cmd    = we && (a == OFF_CMD);
    start_req = wr_cmd && byte_write[CMD_START];
    clr_req   = wr_cmd && byte_write[CMD_CLR];
    wr_blk    = we && (a >= DIN_BASE) && (a < dout_base(N));
    rd_val    = 8'h00;
    if (a == OFF_CMD) begin
      rd_val[CMD_IRQ_EN] = irq_en;
    end else if (a == OFF_STATUS) begin
      rd_val[STAT_BUSY]        = busy;
      rd_val[STAT_DONE]        = done;
      rd_val[STAT_ERR_BUSY]    = err_busy;
      rd_val[STAT_ERR_TIMEOUT] = err_timeout;
    end else if (a < kin_base(N)) begin
      rd_val = blk_byte(din, a - DIN_BASE);
    end else if (a < dout_base(N)) begin
      rd_val = blk_byte(kin, a - kin_base(N));
    end else if (a < kout_base(N)) begin
      rd_val = blk_byte(dout, a - dout_base(N));
    end else if (a < map_end(N)) begin
      rd_val = blk_byte(kout, a - kout_base(N));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din       <= '0;
      kin       <= '0;
      irq_en    <= 1'b0;
      byte_read <= 8'h00;
      irq       <= 1'b0;
    end else begin
      if (re) byte_read <= rd_val;
      irq <= done & irq_en;
      if (wr_cmd) irq_en <= byte_write[CMD_IRQ_EN];
      if (wr_blk && !busy) begin
        if (a < kin_base(N)) din[8*(N-1-(a-DIN_BASE)) +: 8] <= byte_write;
        else                 kin[8*(N-1-(a-kin_base(N))) +: 8] <= byte_write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      core_set    <= 1'b1;
      run_cnt     <= '0;
      done        <= 1'b0;
      err_busy    <= 1'b0;
      err_timeout <= 1'b0;
      dout        <= '0;
      kout        <= '0;
      core_din    <= '0;
      core_kin    <= '0;
    end else begin
      if (clr_req) begin
        done        <= 1'b0;
        err_busy    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (busy && (start_req || wr_blk)) err_busy <= 1'b1;
      case (state)
        S_IDLE: begin
          // Core inputs are captured on entry to LOAD so the core samples them while set is still high.
          if (start_req) begin
            state    <= S_LOAD;
            core_din <= din;
            core_kin <= kin;
          end
        end
        S_LOAD: begin
          state    <= S_RUN;
          core_set <= 1'b0;
          run_cnt  <= '0;
        end
        S_RUN: begin
          if (core_status) begin
            state    <= S_CAPTURE;
            core_set <= 1'b1;
          end else if (run_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= S_IDLE;
            core_set    <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          // Placed after the clr handling so a same-cycle clr cannot drop done.
          dout  <= core_dout;
          kout  <= core_kout;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  Encrypter #(
    .W      (W),
    .ROUNDS (CORE_ROUNDS)
  ) u_core (
    .data_in  (core_din),
    .key_in   (core_kin),
    .clk      (clk),
    .set      (core_set),
    .status   (core_status),
    .key_out  (core_kout),
    .data_out (core_dout)
  );

endmodule

// File: tb/tb_crypt_reg_if.sv
// Scoreboard bench for crypt_reg_if across four builds (N=8, N=4, N=16, and an N=8 build whose core never finishes).
// Reads push expected bytes into a queue; a monitor pops and compares each returned byte and irq.
module tb_crypt_reg_if;
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdat [NI];
  logic [6:0] addr [NI];
  logic       we   [NI];
  logic       re   [NI];
  logic [7:0] rdat [NI];
  logic       irq  [NI];

  always #5 clk = ~clk;

  crypt_reg_if u0 (
    .clk(clk), .rst(rst), .byte_write(wdat[0]), .addr(addr[0][5:0]),
    .we(we[0]), .re(re[0]), .byte_read(rdat[0]), .irq(irq[0]));

  crypt_reg_if #(.BLOCK_BYTES(4), .TIMEOUT_CYCLES(1024), .ADDR_W(5), .CORE_ROUNDS(5)) u1 (
    .clk(clk), .rst(rst), .byte_write(wdat[1]), .addr(addr[1][4:0]),
    .we(we[1]), .re(re[1]), .byte_read(rdat[1]), .irq(irq[1]));

  crypt_reg_if #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(1024), .ADDR_W(7), .CORE_ROUNDS(16)) u2 (
    .clk(clk), .rst(rst), .byte_write(wdat[2]), .addr(addr[2]),
    .we(we[2]), .re(re[2]), .byte_read(rdat[2]), .irq(irq[2]));

  crypt_reg_if #(.BLOCK_BYTES(8), .TIMEOUT_CYCLES(16), .ADDR_W(6), .CORE_ROUNDS(1000)) u3 (
    .clk(clk), .rst(rst), .byte_write(wdat[3]), .addr(addr[3][5:0]),
    .we(we[3]), .re(re[3]), .byte_read(rdat[3]), .irq(irq[3]));

  int tests  = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    int         a;
    logic [7:0] exp_byte;
    logic       exp_irq;
    string      tag;
  } item_t;

  item_t sbq[$];
  item_t mon_it;
  logic  rd_seen [NI];

  // Reference model: register contents as plain byte arrays and flags.
  bit [7:0] m_in  [NI][32];
  bit [7:0] m_out [NI][32];
  bit       m_irqen [NI];
  bit       m_done  [NI];
  bit       m_eb    [NI];
  bit       m_et    [NI];
  bit       m_busy  [NI];

  function automatic int nb(input int i);
    case (i)
      1:       return 4;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int rounds(input int i);
    case (i)
      1:       return 5;
      3:       return 1000;
      default: return 16;
    endcase
  endfunction

  function automatic bit [7:0] exp_read(input int i, input int a);
    int n = nb(i);
    if (a == 0) return {6'b0, m_irqen[i], 1'b0};
    if (a == 1) return {4'b0, m_et[i], m_eb[i], m_done[i], m_busy[i]};
    if (a >= 2 && a < 2 + 2 * n) return m_in[i][a-2];
    if (a >= 2 + 2 * n && a < 2 + 4 * n) return m_out[i][a-2-2*n];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int b = 0; b < 32; b++) begin
        m_in[i][b]  = 8'h00;
        m_out[i][b] = 8'h00;
      end
      m_irqen[i] = 0; m_done[i] = 0; m_eb[i] = 0; m_et[i] = 0; m_busy[i] = 0;
    end
  endtask

  task automatic model_write(input int i, input int a, input bit [7:0] d);
    int n = nb(i);
    if (a == 0) begin
      if (d[2]) begin m_done[i] = 0; m_eb[i] = 0; m_et[i] = 0; end
      m_irqen[i] = d[1];
      if (d[0]) begin
        if (m_busy[i]) m_eb[i] = 1;
        else           m_busy[i] = 1;
      end
    end else if (a >= 2 && a < 2 + 2 * n) begin
      if (m_busy[i]) m_eb[i] = 1;
      else           m_in[i][a-2] = d;
    end
  endtask

  task automatic model_finish(input int i);
    int n = nb(i);
    int w = 8 * n;
    bit [127:0] mask, d, k, nd;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    d = '0;
    k = '0;
    for (int b = 0; b < n; b++) begin
      d = (d << 8) | 128'(m_in[i][b]);
      k = (k << 8) | 128'(m_in[i][n+b]);
    end
    for (int r = 0; r < rounds(i); r++) begin
      nd = (((d << 1) | (d >> (w - 1))) & mask) ^ k;
      k  = ((k << 3) | (k >> (w - 3))) & mask;
      d  = nd;
    end
    for (int b = 0; b < n; b++) begin
      m_out[i][b]   = d[8*(n-1-b) +: 8];
      m_out[i][n+b] = k[8*(n-1-b) +: 8];
    end
    m_done[i] = 1;
    m_busy[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  task automatic wr(input int i, input int a, input bit [7:0] d);
    model_write(i, a, d);
    addr[i] = 7'(a);
    wdat[i] = d;
    we[i]   = 1'b1;
    tick();
    we[i]   = 1'b0;
  endtask

  task automatic push_exp(input int i, input int a, input string tag);
    item_t it;
    it.idx      = i;
    it.a        = a;
    it.exp_byte = exp_read(i, a);
    it.exp_irq  = m_done[i] & m_irqen[i];
    it.tag      = tag;
    sbq.push_back(it);
  endtask

  task automatic rd(input int i, input int a, input string tag);
    push_exp(i, a, tag);
    addr[i] = 7'(a);
    re[i]   = 1'b1;
    tick();
    re[i]   = 1'b0;
  endtask

  task automatic wrrd(input int i, input int a, input bit [7:0] d, input string tag);
    push_exp(i, a, tag);
    model_write(i, a, d);
    addr[i] = 7'(a);
    wdat[i] = d;
    we[i]   = 1'b1;
    re[i]   = 1'b1;
    tick();
    we[i]   = 1'b0;
    re[i]   = 1'b0;
  endtask

  task automatic read_map(input int i, input string tag);
    for (int a = 0; a < 4 * nb(i) + 4; a++) rd(i, a, tag);
  endtask

  task automatic run_txn(input int i, input bit [127:0] d, input bit [127:0] k, input bit [7:0] cmd);
    int n = nb(i);
    for (int b = 0; b < n; b++) begin
      wr(i, 2 + b, d[8*(n-1-b) +: 8]);
      wr(i, 2 + n + b, k[8*(n-1-b) +: 8]);
    end
    wr(i, 0, cmd);
    rd(i, 1, "status_busy");
    repeat (rounds(i) + 2) tick();
    model_finish(i);
    rd(i, 1, "status_done");
    for (int b = 0; b < 2 * n; b++) rd(i, 2 + 2 * n + b, "block_out");
    rd(i, 0, "cmd_readback");
    rd(i, 2 + $urandom_range(0, 2 * n - 1), "block_in");
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) rd_seen[i] <= re[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd_seen[i] === 1'b1) begin
        tests++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read inst=%0d byte=%02h", i, rdat[i]);
        end else begin
          mon_it = sbq.pop_front();
          if (mon_it.idx != i || rdat[i] !== mon_it.exp_byte || irq[i] !== mon_it.exp_irq) begin
            errors++;
            $display("FAIL %s inst=%0d addr=%0d got byte=%02h irq=%0b want byte=%02h irq=%0b (inst %0d)",
                     mon_it.tag, i, mon_it.a, rdat[i], irq[i], mon_it.exp_byte, mon_it.exp_irq, mon_it.idx);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
    end
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < NI; i++) begin
      chk("reset_byte_read", rdat[i], 8'h00);
      chk("reset_irq", {7'b0, irq[i]}, 8'h00);
    end
    for (int i = 0; i < NI; i++) read_map(i, "reset_map");

    // Reference vector on the N=8 build, with irq enabled.
    run_txn(0, 128'h0123456789ABCDEF, 128'h133457799BBCDFF1, 8'h03);

    // Start and a DATA_IN write while running: both flagged, write discarded, done stays set.
    wr(0, 0, 8'h03);
    repeat (3) tick();
    wr(0, 0, 8'h03);
    wr(0, 2, 8'hAA);
    rd(0, 1, "status_err_busy_running");
    repeat (rounds(0) + 2) tick();
    model_finish(0);
    rd(0, 1, "status_err_busy_after");
    rd(0, 2, "din0_unchanged");
    for (int b = 0; b < 16; b++) rd(0, 18 + b, "block_out_rerun");

    // Timeout build: RUN lasts exactly 16 cycles, outputs untouched.
    wr(3, 0, 8'h03);
    repeat (16) tick();
    rd(3, 1, "timeout_still_busy");
    m_et[3]   = 1;
    m_busy[3] = 0;
    rd(3, 1, "timeout_flag");
    for (int b = 0; b < 16; b++) rd(3, 18 + b, "timeout_out_unchanged");

    // Random transactions on the three working builds.
    for (int t = 0; t < 6; t++) begin
      bit en;
      bit cl;
      bit [127:0] d;
      bit [127:0] k;
      en = 1'($urandom_range(0, 1));
      cl = 1'($urandom_range(0, 1));
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(t % 3, d, k, {5'b0, cl, en, 1'b1});
    end

    // Start+clr, a rejected write while busy, then clr landing in the CAPTURE cycle.
    wr(0, 0, 8'h05);
    wr(0, 3, 8'h5A);
    repeat (rounds(0) + 1) tick();
    wr(0, 0, 8'h04);
    model_finish(0);
    rd(0, 1, "clr_in_capture");
    for (int b = 0; b < 16; b++) rd(0, 18 + b, "block_out_clr");

    // Simultaneous write and read returns the old byte.
    wr(0, 2, 8'h11);
    wrrd(0, 2, 8'h22, "rw_same_cycle_old");
    rd(0, 2, "rw_same_cycle_new");

    // Reset in the middle of RUN.
    wr(0, 0, 8'h03);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk("midrun_reset_byte_read", rdat[i], 8'h00);
      chk("midrun_reset_irq", {7'b0, irq[i]}, 8'h00);
    end
    read_map(0, "midrun_reset_map");
    run_txn(0, 128'h0123456789ABCDEF, 128'h133457799BBCDFF1, 8'h03);

    repeat (4) tick();
    tests++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
